// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: CPU-side interrupt entry/ERET sequencer with a hardware nesting stack.
// Ports: in_CLK/in_RST (sync, active-high); controller side in_break, in_code, out_IG, out_INM, out_IE;
// retire side in_inst_done, in_eret, in_PC, in_ie_set, in_ie_clr, in_inm_wr, in_inm_val;
// PC side out_vector_load, out_vector, out_stall; status out_depth, out_err.
// Macro INT_NEST_EN: when defined, IE is re-enabled automatically as the vector is loaded.
module interrupt_sequencer #(
  parameter int PC_W = 32,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] VEC_BASE = 'h100,
  parameter int VEC_STRIDE = 4
) (
  input  logic            in_CLK,
  input  logic            in_RST,
  input  logic            in_break,
  input  logic [1:0]      in_code,
  input  logic            in_inst_done,
  input  logic            in_eret,
  input  logic [PC_W-1:0] in_PC,
  input  logic            in_ie_set,
  input  logic            in_ie_clr,
  input  logic            in_inm_wr,
  input  logic [3:0]      in_inm_val,
  output logic [3:0]      out_IG,
  output logic [3:0]      out_INM,
  output logic            out_IE,
  output logic            out_vector_load,
  output logic [PC_W-1:0] out_vector,
  output logic            out_stall,
  output logic [2:0]      out_depth,
  output logic            out_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ACK, VEC, RET} state_t;
  state_t state, state_n;
  logic [1:0] code;
  logic [PC_W-1:0] pc_l;
  logic do_ret, do_take, do_err, do_upd;
  logic [AW-1:0] push_idx, pop_idx;
  logic [PC_W-1:0] stk_pc [DEPTH];
  logic [3:0] stk_inm [DEPTH];
  logic stk_ie [DEPTH];
  assign push_idx = AW'(out_depth);
  assign pop_idx = AW'(out_depth - 3'd1);
  assign out_IG = (state == ACK) ? 4'b0001 << code : 4'b0000;
  assign out_vector_load = (state == VEC) || (state == RET);
  assign out_stall = state != IDLE;
  always_ff @(posedge in_CLK)
    if (in_RST) state <= IDLE;
    else state <= state_n;
  // ERET outranks a break at the same boundary; software IE/mask writes only land on quiet cycles.
  always_comb begin
    state_n = IDLE;
    do_ret = 1'b0;
    do_take = 1'b0;
    do_err = 1'b0;
    do_upd = 1'b0;
    if (state == IDLE) begin
      if (in_eret && in_inst_done) begin
        do_ret = out_depth != 3'd0;
        do_err = !do_ret;
      end else if (in_break && in_inst_done && out_IE) begin
        do_take = out_depth < 3'(DEPTH);
        do_err = !do_take;
      end else do_upd = 1'b1;
      state_n = do_ret ? RET : do_take ? ACK : IDLE;
    end else state_n = (state == ACK) ? VEC : IDLE;
  end
  always_ff @(posedge in_CLK)
    if (state == ACK) begin
      stk_pc[push_idx] <= pc_l;
      stk_inm[push_idx] <= out_INM;
      stk_ie[push_idx] <= out_IE;
    end
  // The pop happens as ERET is accepted so the restored context is already visible while RET loads the PC.
  always_ff @(posedge in_CLK)
    if (in_RST) begin
      out_INM <= 4'b0000;
      out_IE <= 1'b0;
      out_depth <= 3'd0;
      out_vector <= '0;
      out_err <= 1'b0;
      code <= 2'd0;
      pc_l <= '0;
    end else begin
      out_err <= do_err;
      if (do_take) begin
        code <= in_code;
        pc_l <= in_PC;
      end
      if (do_ret) begin
        out_vector <= stk_pc[pop_idx];
        out_INM <= stk_inm[pop_idx];
        out_IE <= stk_ie[pop_idx];
        out_depth <= out_depth - 3'd1;
      end
      if (do_upd) begin
        out_IE <= in_ie_clr ? 1'b0 : in_ie_set ? 1'b1 : out_IE;
        out_INM <= in_inm_wr ? in_inm_val : out_INM;
      end
      if (state == ACK) begin
        out_INM <= out_INM | 4'((5'd2 << code) - 5'd1);
        out_IE <= 1'b0;
        out_depth <= out_depth + 3'd1;
        out_vector <= VEC_BASE + PC_W'(code) * PC_W'(VEC_STRIDE);
      end
`ifdef INT_NEST_EN
      if (state == VEC) out_IE <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed and random checks of interrupt_sequencer against a cycle-plan reference model.
module tb_interrupt_sequencer;
`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam logic [31:0] VEC_BASE = 32'h100;
  localparam int VEC_STRIDE = 4;
  logic in_CLK = 1'b0, in_RST, in_break, in_inst_done, in_eret, in_ie_set, in_ie_clr, in_inm_wr;
  logic [1:0] in_code;
  logic [31:0] in_PC;
  logic [3:0] in_inm_val;
  logic [3:0] out_IG, out_INM;
  logic out_IE, out_vector_load, out_stall, out_err;
  logic [31:0] out_vector;
  logic [2:0] out_depth;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [3:0] ig; logic vl; logic push; logic [1:0] k; logic [31:0] pc;} slot_t;
  typedef struct packed {logic [31:0] pc; logic [3:0] inm; logic ie;} frame_t;
  slot_t plan[$];
  frame_t frames[$];
  slot_t cur = '0;
  bit busy = 1'b0;
  logic [3:0] m_inm = '0;
  logic m_ie = 1'b0, m_err = 1'b0;
  logic [31:0] m_vec = '0;
  interrupt_sequencer #(.PC_W(32), .DEPTH(DEPTH), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)) dut (
    .in_CLK(in_CLK), .in_RST(in_RST), .in_break(in_break), .in_code(in_code),
    .in_inst_done(in_inst_done), .in_eret(in_eret), .in_PC(in_PC), .in_ie_set(in_ie_set),
    .in_ie_clr(in_ie_clr), .in_inm_wr(in_inm_wr), .in_inm_val(in_inm_val), .out_IG(out_IG),
    .out_INM(out_INM), .out_IE(out_IE), .out_vector_load(out_vector_load), .out_vector(out_vector),
    .out_stall(out_stall), .out_depth(out_depth), .out_err(out_err)
  );
  always #5 in_CLK = ~in_CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic idle_in();
    in_RST = 1'b0;
    in_break = 1'b0;
    in_code = 2'd0;
    in_inst_done = 1'b0;
    in_eret = 1'b0;
    in_PC = '0;
    in_ie_set = 1'b0;
    in_ie_clr = 1'b0;
    in_inm_wr = 1'b0;
    in_inm_val = '0;
  endtask
  // Model: an accepted event becomes a list of future cycles (grant cycle, vector cycle or return cycle);
  // while that list is non-empty the sequencer is busy and ignores new events.
  task automatic tick();
    frame_t f;
    slot_t s;
    if (in_RST) begin
      plan.delete();
      frames.delete();
      busy = 1'b0;
      cur = '0;
      m_inm = '0;
      m_ie = 1'b0;
      m_vec = '0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (busy && cur.push && NEST) m_ie = 1'b1;
      if (!busy) begin
        if (in_eret && in_inst_done) begin
          if (frames.size() > 0) begin
            f = frames.pop_back();
            m_inm = f.inm;
            m_ie = f.ie;
            m_vec = f.pc;
            s = '0;
            s.vl = 1'b1;
            plan.push_back(s);
          end else m_err = 1'b1;
        end else if (in_break && in_inst_done && m_ie) begin
          if (frames.size() < DEPTH) begin
            s = '0;
            s.ig = 4'(1 << in_code);
            plan.push_back(s);
            s = '0;
            s.vl = 1'b1;
            s.push = 1'b1;
            s.k = in_code;
            s.pc = in_PC;
            plan.push_back(s);
          end else m_err = 1'b1;
        end else begin
          if (in_ie_clr) m_ie = 1'b0;
          else if (in_ie_set) m_ie = 1'b1;
          if (in_inm_wr) m_inm = in_inm_val;
        end
      end
      busy = plan.size() > 0;
      cur = busy ? plan.pop_front() : '0;
      if (cur.push) begin
        f.pc = cur.pc;
        f.inm = m_inm;
        f.ie = m_ie;
        frames.push_back(f);
        for (int b = 0; b <= int'(cur.k); b++) m_inm[b] = 1'b1;
        m_ie = 1'b0;
        m_vec = VEC_BASE + 32'(cur.k) * VEC_STRIDE;
      end
    end
    @(posedge in_CLK);
    @(negedge in_CLK);
    check("ig", 32'(out_IG), 32'(cur.ig));
    check("vload", 32'(out_vector_load), 32'(cur.vl));
    check("vector", out_vector, m_vec);
    check("inm", 32'(out_INM), 32'(m_inm));
    check("ie", 32'(out_IE), 32'(m_ie));
    check("depth", 32'(out_depth), frames.size());
    check("stall", 32'(out_stall), 32'(busy));
    check("err", 32'(out_err), 32'(m_err));
  endtask
  task automatic take(input logic [1:0] code, input logic [31:0] pc);
    in_break = 1'b1;
    in_inst_done = 1'b1;
    in_code = code;
    in_PC = pc;
    tick();
    idle_in();
  endtask
  task automatic eret();
    in_eret = 1'b1;
    in_inst_done = 1'b1;
    tick();
    idle_in();
  endtask
  task automatic ei();
    in_ie_set = 1'b1;
    tick();
    idle_in();
  endtask
  initial begin
    idle_in();
    in_RST = 1'b1;
    tick();
    tick();
    check("rst_depth", 32'(out_depth), 0);
    check("rst_ie", 32'(out_IE), 0);
    idle_in();
    ei();
    take(2'd2, 32'h40);
    check("ex_ig", 32'(out_IG), 32'h4);
    tick();
    check("ex_vec", out_vector, 32'h108);
    check("ex_load", 32'(out_vector_load), 1);
    check("ex_inm", 32'(out_INM), 32'h7);
    check("ex_depth", 32'(out_depth), 1);
    tick();
    eret();
    check("ret_vec", out_vector, 32'h40);
    check("ret_inm", 32'(out_INM), 0);
    check("ret_ie", 32'(out_IE), 1);
    check("ret_depth", 32'(out_depth), 0);
    tick();
    take(2'd1, 32'h80);
    tick();
    tick();
    ei();
    take(2'd3, 32'h90);
    tick();
    check("nest_vec", out_vector, 32'h10C);
    check("nest_depth", 32'(out_depth), 2);
    check("nest_inm", 32'(out_INM), 32'hF);
    tick();
    eret();
    check("nest_ret1_inm", 32'(out_INM), 32'h3);
    tick();
    eret();
    check("nest_ret2_inm", 32'(out_INM), 0);
    tick();
    eret();
    check("eret0_err", 32'(out_err), 1);
    check("eret0_load", 32'(out_vector_load), 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      ei();
      take(2'(i), 32'h1000 + 32'(i));
      tick();
      tick();
    end
    ei();
    take(2'd3, 32'h2000);
    check("full_err", 32'(out_err), 1);
    check("full_ig", 32'(out_IG), 0);
    check("full_depth", 32'(out_depth), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      eret();
      tick();
    end
    ei();
    take(2'd0, 32'h300);
    tick();
    in_RST = 1'b1;
    tick();
    idle_in();
    check("rstvec_depth", 32'(out_depth), 0);
    check("rstvec_load", 32'(out_vector_load), 0);
    check("rstvec_vec", out_vector, 0);
    ei();
    take(2'd1, 32'h500);
    tick();
    tick();
    ei();
    in_eret = 1'b1;
    in_break = 1'b1;
    in_inst_done = 1'b1;
    in_code = 2'd2;
    in_PC = 32'h600;
    tick();
    in_eret = 1'b0;
    tick();
    tick();
    idle_in();
    tick();
    tick();
    for (int i = 0; i < 3000; i++) begin
      in_RST = $urandom_range(99) == 0;
      in_break = $urandom_range(99) < 40;
      in_code = 2'($urandom);
      in_inst_done = $urandom_range(99) < 70;
      in_eret = $urandom_range(99) < 15;
      in_PC = $urandom;
      in_ie_set = $urandom_range(99) < 25;
      in_ie_clr = $urandom_range(99) < 5;
      in_inm_wr = $urandom_range(99) < 5;
      in_inm_val = 4'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
